// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID register, with stall, redirect and out-of-range handling.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] WORD_LIMIT = IMEM_WORDS;

  // The PC is kept as a word index so its two low bits can never be nonzero.
  logic [29:0] pc_word;
  logic [29:0] pc_word_inc;
  logic        in_range;
  logic        unused_bits;

  assign pc_word_inc = pc_word + 30'd1;
  assign in_range    = ({2'b00, pc_word} < WORD_LIMIT);
  assign imem_addr   = {pc_word, 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // Priority: redirect over stall over normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_word     <= RESET_PC[31:2];
      ifid_instr  <= NOP_WORD;
      ifid_pc4    <= 32'h0000_0000;
      ifid_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_word    <= redirect_pc[31:2];
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc_word  <= pc_word_inc;
      ifid_pc4 <= {pc_word_inc, 2'b00};
      if (in_range) begin
        ifid_instr  <= imem_rdata;
        ifid_valid  <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else begin
        ifid_instr  <= NOP_WORD;
        ifid_valid  <= 1'b0;
        fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 32-word instance for the main flow and a
// 2^30-word instance for the address-wrap case.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] ifid_instr2;
  logic [31:0] ifid_pc42;
  logic        ifid_valid2;
  logic        fetch_fault2;
  logic [31:0] fetch_count2;

  logic [31:0] mem [0:31];
  int total = 0;
  int bad   = 0;

  if_stage #(.IMEM_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  if_stage #(.IMEM_WORDS(32'h4000_0000)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42), .ifid_valid(ifid_valid2),
    .fetch_fault(fetch_fault2), .fetch_count(fetch_count2)
  );

  assign imem_rdata  = mem[imem_addr[6:2]];
  assign imem_rdata2 = imem_addr2 ^ 32'hA5A5_0000;

  initial begin
    clk = 1'b0;
    forever #1000 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the 32-word instance, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #10;
  endtask

  initial begin
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;
    for (int i = 4; i < 32; i++) mem[i] = 32'h1000_0000 | i;

    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = 32'h0;
    #10;
    checkOutput("rst_addr",  imem_addr,   32'h0);
    checkOutput("rst_instr", ifid_instr,  32'h0);
    checkOutput("rst_pc4",   ifid_pc4,    32'h0);
    checkOutput("rst_valid", {31'b0, ifid_valid},  32'h0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
    checkOutput("rst_count", fetch_count, 32'h0);
    #490;
    rst_n = 1'b1;

    // Four free-running fetches.
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("run1_addr",  imem_addr,  32'h4);
    checkOutput("run1_instr", ifid_instr, 32'h2008_0005);
    checkOutput("run1_pc4",   ifid_pc4,   32'h4);
    checkOutput("run1_valid", {31'b0, ifid_valid}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("run2_instr", ifid_instr, 32'h2009_0003);
    checkOutput("run2_pc4",   ifid_pc4,   32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("run3_instr", ifid_instr, 32'h0109_5020);
    checkOutput("run3_pc4",   ifid_pc4,   32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("run4_addr",  imem_addr,  32'h10);
    checkOutput("run4_instr", ifid_instr, 32'hAC0A_0000);
    checkOutput("run4_pc4",   ifid_pc4,   32'h10);
    checkOutput("run4_count", fetch_count, 32'd4);

    // Redirect back to 4 so word 1 sits in IF/ID with pc=8.
    applyStimulus(1'b0, 1'b1, 32'h4);
    checkOutput("redir4_addr",  imem_addr,  32'h4);
    checkOutput("redir4_valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("redir4_pc4",   ifid_pc4,   32'h10);
    checkOutput("redir4_count", fetch_count, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pre_stall_instr", ifid_instr, 32'h2009_0003);
    checkOutput("pre_stall_count", fetch_count, 32'd5);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_addr",  imem_addr,  32'h8);
      checkOutput("stall_instr", ifid_instr, 32'h2009_0003);
      checkOutput("stall_pc4",   ifid_pc4,   32'h8);
      checkOutput("stall_valid", {31'b0, ifid_valid}, 32'h1);
      checkOutput("stall_count", fetch_count, 32'd5);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("resume_instr", ifid_instr, 32'h0109_5020);
    checkOutput("resume_addr",  imem_addr,  32'hC);
    checkOutput("resume_count", fetch_count, 32'd6);

    // Redirect beats a simultaneous stall; misaligned target is aligned.
    applyStimulus(1'b1, 1'b1, 32'h0000_0013);
    checkOutput("rds_addr",  imem_addr,  32'h10);
    checkOutput("rds_valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("rds_instr", ifid_instr, 32'h0);
    checkOutput("rds_pc4",   ifid_pc4,   32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("tgt_instr", ifid_instr, 32'h1000_0004);
    checkOutput("tgt_pc4",   ifid_pc4,   32'h14);
    checkOutput("tgt_count", fetch_count, 32'd7);

    // Last legal word, then the first out-of-range fetch.
    applyStimulus(1'b0, 1'b1, 32'h7C);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("w31_instr", ifid_instr, 32'h1000_001F);
    checkOutput("w31_pc4",   ifid_pc4,   32'h80);
    checkOutput("w31_fault", {31'b0, fetch_fault}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("oor_valid", {31'b0, ifid_valid}, 32'h0);
    checkOutput("oor_instr", ifid_instr, 32'h0);
    checkOutput("oor_pc4",   ifid_pc4,   32'h84);
    checkOutput("oor_fault", {31'b0, fetch_fault}, 32'h1);
    checkOutput("oor_count", fetch_count, 32'd8);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("oor_redir_fault", {31'b0, fetch_fault}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("back_instr", ifid_instr, 32'h2008_0005);
    checkOutput("back_valid", {31'b0, ifid_valid}, 32'h1);
    checkOutput("back_fault", {31'b0, fetch_fault}, 32'h1);
    checkOutput("back_count", fetch_count, 32'd9);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Asynchronous reset between edges.
    #500;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_addr",  imem_addr,   32'h0);
    checkOutput("arst_instr", ifid_instr,  32'h0);
    checkOutput("arst_pc4",   ifid_pc4,    32'h0);
    checkOutput("arst_valid", {31'b0, ifid_valid},  32'h0);
    checkOutput("arst_fault", {31'b0, fetch_fault}, 32'h0);
    checkOutput("arst_count", fetch_count, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("arst_hold_addr", imem_addr, 32'h0);
    #500;
    rst_n = 1'b1;

    // Wrap case on the large instance alongside a fresh fetch on the small one.
    redirect_valid2 = 1'b1;
    redirect_pc2    = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_rst_instr", ifid_instr, 32'h2008_0005);
    checkOutput("post_rst_count", fetch_count, 32'd1);
    checkOutput("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    redirect_valid2 = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_next_addr", imem_addr2,  32'h0);
    checkOutput("wrap_instr",     ifid_instr2, 32'h5A5A_FFFC);
    checkOutput("wrap_pc4",       ifid_pc42,   32'h0);
    checkOutput("wrap_valid",     {31'b0, ifid_valid2}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_w0_instr", ifid_instr2, 32'hA5A5_0000);
    checkOutput("wrap_w0_pc4",   ifid_pc42,   32'h4);
    checkOutput("wrap_fault",    {31'b0, fetch_fault2}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
